program_counter_unit: RTL

- Program counter register sitting directly downstream of the jump-select mux.
- Each cycle it registers the selected next address (`endereco_proximo`) and feeds `pc` to instruction memory.
- Produces `pc_mais_um` for the sequential/branch path back upstream.
- A small FSM handles stall, wait-for-input instructions and halt.

---
 rtl/program_counter_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/program_counter_unit.sv
// program_counter_unit
// Program counter register fed by the jump-select mux. Registers the next
// address each cycle, exposes pc and pc+1, and runs a small control FSM
// for stall, wait-for-input instructions and halt.
// Optional build macro INSTR_COUNTER_EN adds a saturating count of
// instructions issued (every cycle pc loads endereco_proximo).
module program_counter_unit #(
  parameter int unsigned              ADDR_WIDTH = 13,
  parameter logic [ADDR_WIDTH-1:0]    RESET_ADDR = '0,
  parameter int unsigned              CNT_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] endereco_proximo,
  input  logic                  stall,
  input  logic                  halt,
  input  logic                  espera_entrada,
  input  logic                  entrada_confirmada,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_mais_um,
  output logic                  aguardando,
  output logic                  parado
`ifdef INSTR_COUNTER_EN
  ,
  output logic [CNT_WIDTH-1:0]  instr_count
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_IN = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t state;
  logic   ent_prev;
  logic   ent_edge;
  logic   advance;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_WIDTH'(1);
  endfunction

  // Sequential successor address; wraps modulo 2^ADDR_WIDTH by width truncation.
  assign pc_mais_um = pc + ADDR_WIDTH'(1);

  // Only a fresh 0->1 transition of the confirm level completes a wait.
  assign ent_edge = entrada_confirmada & ~ent_prev;

  // Previous confirm level, tracked in every state so a level held from
  // before the wait is never mistaken for a new press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent_prev <= 1'b0;
    end else begin
      ent_prev <= entrada_confirmada;
    end
  end

  // Decide whether pc takes the next address this cycle. Kept as one
  // signal so the pc register and the instruction counter cannot disagree.
  always_comb begin
    advance = 1'b0;
    case (state)
      RUN:     advance = ~stall & ~halt & ~espera_entrada;
      WAIT_IN: advance = ent_edge;
      default: advance = 1'b0;
    endcase
  end

  // Control FSM with registered pc and registered state-decode outputs.
  // Stall outranks halt, which outranks the input wait; in WAIT_IN and
  // HALTED the stall/halt inputs are not looked at.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      pc         <= RESET_ADDR;
      aguardando <= 1'b0;
      parado     <= 1'b0;
    end else begin
      if (advance) begin
        pc <= endereco_proximo;
      end
      case (state)
        RUN: begin
          if (stall) begin
            state <= RUN;
          end else if (halt) begin
            state  <= HALTED;
            parado <= 1'b1;
          end else if (espera_entrada) begin
            state      <= WAIT_IN;
            aguardando <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        WAIT_IN: begin
          if (ent_edge) begin
            state      <= RUN;
            aguardando <= 1'b0;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          // Unused encoding: recover to RUN without moving pc.
          state      <= RUN;
          aguardando <= 1'b0;
          parado     <= 1'b0;
        end
      endcase
    end
  end

`ifdef INSTR_COUNTER_EN
  // Count issued instructions, saturating at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
    end else if (advance) begin
      instr_count <= sat_inc(instr_count);
    end
  end
`endif

endmodule
